// File: rtl/branch_predictor.sv
// Purpose: branch prediction unit combining a direct-mapped tagged BTB with 2-bit BHT counters, plus saturating statistics.
// Latency: the prediction is combinational, in the same cycle as if_pc. Updates and init writes reach the lookup on the next cycle.
// Backpressure: none. Every upd_* and init write presented with its enable high is consumed in that cycle.
//
// Optional feature: define BPU_GSHARE_EN to XOR a global history register into the BHT index (gshare).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   btb_init_* / bht_init_*     preload a BTB entry {tag, target} or a BHT counter
//   if_pc                       fetch PC
//   pred_*                      hit, taken, target, next PC, BHT index used
//   upd_*                       resolved instruction from MEM
//   mispredict, redirect_pc     combinational flush request and the correct fetch PC
//   stat_clr, stat_*            statistics clear and saturating counters
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int BTB_IDX_W = 8,
  parameter int BTB_TAG_W = 8,
  parameter int BHT_IDX_W = 8,
  parameter int STAT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btb_init_we,
  input  logic [BTB_IDX_W-1:0]      btb_init_addr,
  input  logic [BTB_TAG_W+XLEN-1:0] btb_init_data,
  input  logic                      bht_init_we,
  input  logic [BHT_IDX_W-1:0]      bht_init_addr,
  input  logic [1:0]                bht_init_data,
  input  logic [XLEN-1:0]           if_pc,
  output logic                      pred_hit,
  output logic                      pred_taken,
  output logic [XLEN-1:0]           pred_target,
  output logic [XLEN-1:0]           pred_next_pc,
  output logic [BHT_IDX_W-1:0]      pred_bht_idx,
  input  logic                      upd_valid,
  input  logic                      upd_is_branch,
  input  logic                      upd_taken,
  input  logic [XLEN-1:0]           upd_pc,
  input  logic [XLEN-1:0]           upd_target,
  input  logic                      upd_pred_taken,
  input  logic [XLEN-1:0]           upd_pred_target,
  input  logic [BHT_IDX_W-1:0]      upd_bht_idx,
  output logic                      mispredict,
  output logic [XLEN-1:0]           redirect_pc,
  input  logic                      stat_clr,
  output logic [STAT_W-1:0]         stat_branches,
  output logic [STAT_W-1:0]         stat_mispredicts
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef struct packed {
    logic [BTB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      target;
  } btb_entry_t;

  logic [BTB_N-1:0] btb_valid;
  btb_entry_t       btb_mem [BTB_N];
  logic [1:0]       bht_ctr [BHT_N];

  // Lookup
  logic [BTB_IDX_W-1:0] if_btb_idx;
  logic [BTB_TAG_W-1:0] if_tag;
  btb_entry_t           if_entry;

  assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
  assign if_tag     = if_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
  assign if_entry   = btb_mem[if_btb_idx];

`ifdef BPU_GSHARE_EN
  logic [BHT_IDX_W-1:0] ghr;
  assign pred_bht_idx = if_pc[BHT_IDX_W+1:2] ^ ghr;
`else
  assign pred_bht_idx = if_pc[BHT_IDX_W+1:2];
`endif

  assign pred_hit     = btb_valid[if_btb_idx] && (if_entry.tag == if_tag);
  assign pred_taken   = pred_hit && bht_ctr[pred_bht_idx][1];
  assign pred_target  = if_entry.target;
  assign pred_next_pc = pred_taken ? if_entry.target : if_pc + XLEN'(4);

  // Update decode
  logic                 upd_br;
  logic                 upd_alias;
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic [BTB_TAG_W-1:0] upd_tag;
  logic                 btb_init_same;
  logic                 bht_init_same;

  assign upd_br        = upd_valid && upd_is_branch;
  // A non-branch that was predicted taken hit a BTB entry left by a different PC.
  assign upd_alias     = upd_valid && !upd_is_branch && upd_pred_taken;
  assign upd_btb_idx   = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag       = upd_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
  // An init write to the entry an update targets takes precedence.
  assign btb_init_same = btb_init_we && (btb_init_addr == upd_btb_idx);
  assign bht_init_same = bht_init_we && (bht_init_addr == upd_bht_idx);

  assign mispredict  = (upd_br && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target))))
                     || upd_alias;
  assign redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + XLEN'(4);

  // BTB valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else begin
      if (btb_init_we)
        btb_valid[btb_init_addr] <= 1'b1;
      if (!btb_init_same) begin
        if (upd_br && upd_taken)
          btb_valid[upd_btb_idx] <= 1'b1;
        else if (upd_alias)
          btb_valid[upd_btb_idx] <= 1'b0;
      end
    end
  end

  // BTB tag and target storage. It is not reset because valid=0 masks its contents.
  always_ff @(posedge clk) begin
    if (btb_init_we)
      btb_mem[btb_init_addr] <= btb_init_data;
    if (upd_br && upd_taken && !btb_init_same)
      btb_mem[upd_btb_idx] <= '{tag: upd_tag, target: upd_target};
  end

  // BHT saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++)
        bht_ctr[i] <= 2'b01;
    end else begin
      if (bht_init_we)
        bht_ctr[bht_init_addr] <= bht_init_data;
      if (upd_br && !bht_init_same) begin
        if (upd_taken && bht_ctr[upd_bht_idx] != 2'b11)
          bht_ctr[upd_bht_idx] <= bht_ctr[upd_bht_idx] + 2'b01;
        else if (!upd_taken && bht_ctr[upd_bht_idx] != 2'b00)
          bht_ctr[upd_bht_idx] <= bht_ctr[upd_bht_idx] - 2'b01;
      end
    end
  end

`ifdef BPU_GSHARE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else if (upd_br)
      ghr <= {ghr[BHT_IDX_W-2:0], upd_taken};
  end
`endif

  // Statistics. A clear overrides an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_br && (stat_branches != '1))
        stat_branches <= stat_branches + 1'b1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor in the default build (gshare off).
// Each table row drives the inputs for one cycle. The combinational outputs are checked at the negative clock edge, and the row's update commits at the next rising edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btb_init_we = 1'b0;
  logic [7:0]  btb_init_addr = '0;
  logic [39:0] btb_init_data = '0;
  logic        bht_init_we = 1'b0;
  logic [7:0]  bht_init_addr = '0;
  logic [1:0]  bht_init_data = '0;
  logic [31:0] if_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target, pred_next_pc;
  logic [7:0]  pred_bht_idx;
  logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic [7:0]  upd_bht_idx;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_branches, stat_mispredicts;

  // Without gshare, the index that fetch hands down the pipeline is pc[9:2].
  assign upd_bht_idx = upd_pc[9:2];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .btb_init_we(btb_init_we), .btb_init_addr(btb_init_addr), .btb_init_data(btb_init_data),
    .bht_init_we(bht_init_we), .bht_init_addr(bht_init_addr), .bht_init_data(bht_init_data),
    .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_next_pc(pred_next_pc), .pred_bht_idx(pred_bht_idx),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_bht_idx(upd_bht_idx),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_clr(stat_clr), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] if_pc;
    logic        uv, ub, ut;
    logic [31:0] upc, utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        clr;
    logic        e_hit, e_taken;
    logic [31:0] e_tgt, e_next;
    logic        e_mis;
    logic [31:0] e_redir;
    logic [15:0] e_br, e_mp;
  } row_t;

  function automatic row_t mk(
      input logic [31:0] ipc, input logic uv, ub, ut, input logic [31:0] upc, utgt,
      input logic upt, input logic [31:0] uptgt, input logic clr,
      input logic hit, tk, input logic [31:0] tgt, nxt, input logic mis,
      input logic [31:0] redir, input logic [15:0] br, mp);
    row_t r;
    r.if_pc = ipc; r.uv = uv; r.ub = ub; r.ut = ut; r.upc = upc; r.utgt = utgt;
    r.upt = upt; r.uptgt = uptgt; r.clr = clr;
    r.e_hit = hit; r.e_taken = tk; r.e_tgt = tgt; r.e_next = nxt; r.e_mis = mis;
    r.e_redir = redir; r.e_br = br; r.e_mp = mp;
    return r;
  endfunction

  task automatic idle();
    upd_valid = 0; upd_is_branch = 0; upd_taken = 0; upd_pc = '0; upd_target = '0;
    upd_pred_taken = 0; upd_pred_target = '0; stat_clr = 0;
    btb_init_we = 0; bht_init_we = 0;
  endtask

  task automatic drive_upd(input logic ub, ut, input logic [31:0] pc, tgt,
                           input logic pt, input logic [31:0] ptgt);
    upd_valid = 1; upd_is_branch = ub; upd_taken = ut; upd_pc = pc; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  row_t rows [15];

  initial begin
    //              if_pc        uv ub ut upc          utgt    upt uptgt  clr  hit tk tgt     next         mis redir   br mp
    rows[0]  = mk(32'h100,       0, 0, 0, 32'h0,       32'h0,   0, 32'h0,   0,  0, 0, 32'h0,   32'h104,     0, 32'h4,   0, 0);
    rows[1]  = mk(32'h100,       1, 1, 1, 32'h100,     32'h200, 0, 32'h0,   0,  0, 0, 32'h0,   32'h104,     1, 32'h200, 0, 0);
    rows[2]  = mk(32'h100,       0, 0, 0, 32'h0,       32'h0,   0, 32'h0,   0,  1, 1, 32'h200, 32'h200,     0, 32'h4,   1, 1);
    rows[3]  = mk(32'h100,       1, 1, 1, 32'h100,     32'h200, 1, 32'h200, 1,  1, 1, 32'h200, 32'h200,     0, 32'h200, 1, 1);
    rows[4]  = mk(32'h100,       1, 1, 0, 32'h100,     32'h0,   1, 32'h200, 0,  1, 1, 32'h200, 32'h200,     1, 32'h104, 0, 0);
    rows[5]  = mk(32'h100,       1, 1, 0, 32'h100,     32'h0,   1, 32'h200, 0,  1, 1, 32'h200, 32'h200,     1, 32'h104, 1, 1);
    rows[6]  = mk(32'h100,       1, 1, 0, 32'h100,     32'h0,   0, 32'h0,   0,  1, 0, 32'h200, 32'h104,     0, 32'h104, 2, 2);
    rows[7]  = mk(32'h100,       1, 1, 0, 32'h100,     32'h0,   0, 32'h0,   0,  1, 0, 32'h200, 32'h104,     0, 32'h104, 3, 2);
    rows[8]  = mk(32'h100,       0, 0, 0, 32'h0,       32'h0,   0, 32'h0,   0,  1, 0, 32'h200, 32'h104,     0, 32'h4,   4, 2);
    rows[9]  = mk(32'h140,       1, 1, 1, 32'h140,     32'h300, 0, 32'h0,   0,  0, 0, 32'h0,   32'h144,     1, 32'h300, 4, 2);
    rows[10] = mk(32'h140,       1, 0, 0, 32'h140,     32'h0,   1, 32'h300, 0,  1, 1, 32'h300, 32'h300,     1, 32'h144, 5, 3);
    rows[11] = mk(32'h140,       0, 0, 0, 32'h0,       32'h0,   0, 32'h0,   0,  0, 0, 32'h0,   32'h144,     0, 32'h4,   5, 4);
    rows[12] = mk(32'h500,       1, 1, 1, 32'h100,     32'h180, 1, 32'h200, 0,  0, 0, 32'h0,   32'h504,     1, 32'h180, 5, 4);
    rows[13] = mk(32'hFFFFFFFC,  1, 0, 0, 32'hFFFFFFFC,32'h0,   0, 32'h0,   0,  0, 0, 32'h0,   32'h0,       0, 32'h0,   6, 5);
    rows[14] = mk(32'h100,       0, 0, 0, 32'h0,       32'h0,   0, 32'h0,   0,  1, 0, 32'h180, 32'h104,     0, 32'h4,   6, 5);

    repeat (3) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 15; i++) begin
      if_pc = rows[i].if_pc;
      if (rows[i].uv) drive_upd(rows[i].ub, rows[i].ut, rows[i].upc, rows[i].utgt,
                                rows[i].upt, rows[i].uptgt);
      else idle();
      stat_clr = rows[i].clr;
      @(negedge clk);
      chk($sformatf("row%0d pred_hit", i),     32'(pred_hit),     32'(rows[i].e_hit));
      chk($sformatf("row%0d pred_taken", i),   32'(pred_taken),   32'(rows[i].e_taken));
      if (rows[i].e_hit)
        chk($sformatf("row%0d pred_target", i), pred_target, rows[i].e_tgt);
      chk($sformatf("row%0d pred_next_pc", i), pred_next_pc,      rows[i].e_next);
      chk($sformatf("row%0d pred_bht_idx", i), 32'(pred_bht_idx), 32'(rows[i].if_pc[9:2]));
      chk($sformatf("row%0d mispredict", i),   32'(mispredict),   32'(rows[i].e_mis));
      chk($sformatf("row%0d redirect_pc", i),  redirect_pc,       rows[i].e_redir);
      chk($sformatf("row%0d stat_branches", i),    32'(stat_branches),    32'(rows[i].e_br));
      chk($sformatf("row%0d stat_mispredicts", i), 32'(stat_mispredicts), 32'(rows[i].e_mp));
      @(posedge clk); #1;
    end

    // A BHT init wins over a same-cycle not-taken update to the same counter (currently 01).
    idle();
    if_pc = 32'h100;
    drive_upd(1, 0, 32'h100, 32'h0, 0, 32'h0);
    bht_init_we = 1; bht_init_addr = 8'h40; bht_init_data = 2'b11;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("bht_init_wins taken", 32'(pred_taken), 32'd1);
    chk("bht_init_wins next",  pred_next_pc, 32'h180);
    chk("bht_init_wins br",    32'(stat_branches), 32'd7);
    @(posedge clk); #1;

    // Drive stat_mispredicts into saturation using aliased non-branches at an unused entry.
    drive_upd(0, 0, 32'h3F0, 32'h0, 1, 32'h0);
    repeat (65540) @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("sat mp", 32'(stat_mispredicts), 32'hFFFF);

    // A BTB init and a taken update to index 5 arrive in the same cycle. The init data must be kept.
    @(posedge clk); #1;
    drive_upd(1, 1, 32'h14, 32'h800, 0, 32'h0);
    btb_init_we = 1; btb_init_addr = 8'h05; btb_init_data = {8'h03, 32'h0000AAA0};
    if_pc = 32'hC14;
    @(negedge clk);
    chk("init_upd mis",       32'(mispredict), 32'd1);
    chk("init_upd old hit",   32'(pred_hit),   32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("init_upd hit",    32'(pred_hit),     32'd1);
    chk("init_upd target", pred_target,       32'h0000AAA0);
    chk("init_upd next",   pred_next_pc,      32'h0000AAA0);
    chk("init_upd mp sat", 32'(stat_mispredicts), 32'hFFFF);
    chk("init_upd br",     32'(stat_branches),    32'd8);
    if_pc = 32'h14;
    #1 chk("init_upd tag0 miss", 32'(pred_hit), 32'd0);

    // A clear in the same cycle as a mispredict leaves both counters at zero.
    @(posedge clk); #1;
    drive_upd(1, 1, 32'h14, 32'h900, 0, 32'h0);
    stat_clr = 1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("clr br", 32'(stat_branches),    32'd0);
    chk("clr mp", 32'(stat_mispredicts), 32'd0);

    // A reset in the middle of a cycle with an update pending clears all state at once.
    @(posedge clk); #1;
    if_pc = 32'h100;
    drive_upd(1, 1, 32'h100, 32'h180, 0, 32'h0);
    @(negedge clk);
    chk("pre_rst hit", 32'(pred_hit), 32'd1);
    rst = 1;
    #1;
    chk("mid_rst hit",  32'(pred_hit),      32'd0);
    chk("mid_rst next", pred_next_pc,       32'h104);
    chk("mid_rst br",   32'(stat_branches), 32'd0);
    @(posedge clk); #1;
    idle();
    rst = 0;
    @(negedge clk);
    chk("post_rst hit", 32'(pred_hit),         32'd0);
    chk("post_rst mp",  32'(stat_mispredicts), 32'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
